adc_capture_ctrl: RTL and testbench
===================================

Name: adc_capture_ctrl

Overview:
- Write-side capture controller between the ADC sample source (64-bit words on the 62.5 MHz domain) and the dual-clock capture BRAM (16384 x 64).
- Runs a pre-/post-trigger ring-buffer capture and drives the BRAM write port (wraddress, data, wren, byteen).
- Reports where the captured window starts so the host read-side PIO can walk it from the other clock domain.

Parameters:
- DATA_W, 64, sample word width
- ADDR_W, 14, BRAM address width; depth = 2**ADDR_W = 16384

Ports:
- i_62clk  in  1  capture clock (62.5 MHz ADC domain)
- i_reset  in  1  asynchronous, active-high reset
- i_adc_data  in  DATA_W  sample word from ADC source
- i_adc_valid  in  1  i_adc_data valid this cycle
- i_arm  in  1  single-cycle pulse: start a capture
- i_abort  in  1  single-cycle pulse: cancel, return to IDLE
- i_trig  in  1  trigger qualifier, sampled only with i_adc_valid
- i_capture_len  in  ADDR_W+1  total words per capture; 0 means 16384
- i_pretrig_len  in  ADDR_W  words kept before trigger
- o_wraddress  out  ADDR_W  BRAM write address
- o_wrdata  out  DATA_W  BRAM write data
- o_wren  out  1  BRAM write enable
- o_byteen  out  DATA_W/8  all-ones when o_wren, else 0
- o_busy  out  1  state is PRE, ARMED or POST
- o_done  out  1  capture complete, window valid
- o_start_addr  out  ADDR_W  address of oldest captured word
- o_trig_addr  out  ADDR_W  address holding the trigger word
- o_state  out  3  state encoding, for debug

Behaviour:
- Reset: async, all outputs 0; state IDLE; write pointer 0.
- States: IDLE, PRE, ARMED, POST, DONE.
- Latch on arm:
  - len_eff = (i_capture_len == 0 or > 16384) ? 16384 : i_capture_len.
  - pre_eff = min(i_pretrig_len, len_eff-1).
  - post_eff = len_eff - pre_eff; this count includes the trigger word.
- IDLE/DONE + i_arm:
  - Latch len_eff, pre_eff, post_eff; clear pointer and counters; clear o_done.
  - Go to PRE, or to ARMED if pre_eff == 0.
  - i_arm in PRE, ARMED or POST is ignored.
- Write path: every i_adc_valid in PRE, ARMED or POST writes the word.
  - o_wren, o_wrdata and o_wraddress are registered: they appear exactly 1 cycle after the valid input.
  - The pointer increments mod 16384 after each write; wrap is silent.
- PRE: count valid words. When the count reaches pre_eff (on that word's cycle), go to ARMED. i_trig is ignored in PRE.
- ARMED: keep writing and wrapping.
  - The first cycle with i_adc_valid & i_trig makes that word the trigger word.
  - Record o_trig_addr = its address.
  - o_start_addr = (trig_addr - pre_eff) mod 16384.
  - Go to POST with post counter = 1.
- POST: write valid words until post_eff words (including the trigger word) are written.
  - After the last write, go to DONE; o_done is asserted in the same cycle as that word's o_wren.
  - i_trig is ignored.
  - If post_eff == 1, the transition goes directly ARMED→DONE.
- DONE: no writes. o_done, o_start_addr and o_trig_addr hold until the next arm, abort or reset.
- i_abort:
  - From any state, go to IDLE next cycle; o_done is cleared.
  - A write already registered this cycle still completes.
  - i_abort wins over a simultaneous i_arm or i_trig.
- i_adc_valid low: nothing advances. Counters and state wait; trigger is never taken without valid.
- Window integrity: pre-trigger data is guaranteed pre_eff words deep because trigger is blocked in PRE.
- o_busy = state in {PRE, ARMED, POST}, registered with the state.

Decomposition:
- Package adc_capture_pkg holds:
  - state enum (IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4)
  - ADDR_W/DATA_W defaults
  - BRAM_DEPTH constant
- One natural sub-module: adc_capture_wrport, the registered write-port stage (pointer, wrap, o_wren/o_wrdata/o_byteen).
- The FSM and counters remain in the top.

Test Plan:
- Reset mid-POST: assert i_reset asynchronously → all outputs 0 immediately; state IDLE; next arm restarts at address 0.
- len=16, pretrig=4, continuous valid, counting data; trig on 10th word (addr 9):
  - o_trig_addr=9, o_start_addr=5.
  - Last write is to addr 20.
  - o_done asserted with that write.
  - Exactly 21 wren pulses.
- Wrap: len=0 (16384), pretrig=100, trig at write 20000 (addr 3616):
  - o_start_addr=3516.
  - Capture ends at addr 3515 after 16284 post words.
- Early trigger: pretrig=8, i_trig high from arm onward → trigger taken on 9th word (addr 8); o_start_addr=0.
- Gapped valid (1 in 3), len=4, pretrig=0 → wren every 3rd cycle, each 1 cycle after valid; DONE after 4 writes; addr 0..3.
- Abort in ARMED with simultaneous i_arm → IDLE; o_done=0; no further wren; i_arm ignored that cycle.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture controller slice.
package adc_capture_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 14;
  localparam int BRAM_DEPTH = 1 << ADDR_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

endpackage

// File: rtl/adc_capture_wrport.sv
// Registered BRAM write-port stage: owns the ring pointer and presents each
// accepted word on the BRAM port one cycle after it is requested.
module adc_capture_wrport
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_req,
  input  logic [DATA_W-1:0]     data,
  output logic [ADDR_W-1:0]     wraddress,
  output logic [DATA_W-1:0]     wrdata,
  output logic                  wren,
  output logic [DATA_W/8-1:0]   byteen,
  output logic [ADDR_W-1:0]     ptr
);

  // The pointer wraps naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wraddress <= '0;
      wrdata    <= '0;
      wren      <= 1'b0;
      byteen    <= '0;
      ptr       <= '0;
    end else begin
      wren   <= wr_req;
      byteen <= wr_req ? '1 : '0;
      if (clr) begin
        ptr <= '0;
      end else if (wr_req) begin
        wraddress <= ptr;
        wrdata    <= data;
        ptr       <= ptr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Pre-/post-trigger ring-buffer capture controller driving the write side of
// the dual-clock capture BRAM and reporting the captured window location.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  i_62clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_adc_data,
  input  logic                  i_adc_valid,
  input  logic                  i_arm,
  input  logic                  i_abort,
  input  logic                  i_trig,
  input  logic [ADDR_W:0]       i_capture_len,
  input  logic [ADDR_W-1:0]     i_pretrig_len,
  output logic [ADDR_W-1:0]     o_wraddress,
  output logic [DATA_W-1:0]     o_wrdata,
  output logic                  o_wren,
  output logic [DATA_W/8-1:0]   o_byteen,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_W-1:0]     o_start_addr,
  output logic [ADDR_W-1:0]     o_trig_addr,
  output logic [2:0]            o_state
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_PRE   = ST_PRE;
  localparam logic [2:0] S_ARMED = ST_ARMED;
  localparam logic [2:0] S_POST  = ST_POST;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] pre_eff, pre_cnt, pre_cnt_nxt;
  logic [ADDR_W:0]   post_eff, post_cnt, post_cnt_nxt;
  logic [ADDR_W:0]   len_eff_c, post_eff_c;
  logic [ADDR_W-1:0] pre_eff_c;
  logic [ADDR_W-1:0] wr_ptr;
  logic              idle_like, capturing, arm_ok, wr_req;

  assign idle_like   = (state == S_IDLE) || (state == S_DONE);
  assign capturing   = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign arm_ok      = i_arm && !i_abort && idle_like;
  assign wr_req      = i_adc_valid && !i_abort && capturing;
  assign pre_cnt_nxt  = pre_cnt + ADDR_W'(1);
  assign post_cnt_nxt = post_cnt + (ADDR_W+1)'(1);

  // Window sizes as they would be latched if an arm were accepted this cycle.
  always_comb begin
    len_eff_c = ((i_capture_len == '0) || (i_capture_len > DEPTH)) ? DEPTH : i_capture_len;
    pre_eff_c = ({1'b0, i_pretrig_len} < len_eff_c) ? i_pretrig_len
                                                    : ADDR_W'(len_eff_c - (ADDR_W+1)'(1));
    post_eff_c = len_eff_c - {1'b0, pre_eff_c};
  end

  always_comb begin
    state_nxt = state;
    if (i_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (i_arm) state_nxt = (pre_eff_c == '0) ? S_ARMED : S_PRE;
        S_PRE:
          if (i_adc_valid && (pre_cnt_nxt == pre_eff)) state_nxt = S_ARMED;
        S_ARMED:
          if (i_adc_valid && i_trig)
            state_nxt = (post_eff == (ADDR_W+1)'(1)) ? S_DONE : S_POST;
        S_POST:
          if (i_adc_valid && (post_cnt_nxt == post_eff)) state_nxt = S_DONE;
        default:
          state_nxt = S_IDLE;
      endcase
    end
  end

  // o_done is set on the same edge that registers the final write, so it
  // rises together with that word's o_wren.
  always_ff @(posedge i_62clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_start_addr <= '0;
      o_trig_addr  <= '0;
      pre_eff      <= '0;
      post_eff     <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
    end else begin
      state  <= state_nxt;
      o_busy <= (state_nxt == S_PRE) || (state_nxt == S_ARMED) || (state_nxt == S_POST);
      if (i_abort) begin
        o_done       <= 1'b0;
        o_start_addr <= '0;
        o_trig_addr  <= '0;
      end else if (arm_ok) begin
        pre_eff      <= pre_eff_c;
        post_eff     <= post_eff_c;
        pre_cnt      <= '0;
        post_cnt     <= '0;
        o_done       <= 1'b0;
        o_start_addr <= '0;
        o_trig_addr  <= '0;
      end else if (wr_req) begin
        case (state)
          S_PRE: pre_cnt <= pre_cnt_nxt;
          S_ARMED:
            if (i_trig) begin
              o_trig_addr  <= wr_ptr;
              o_start_addr <= wr_ptr - pre_eff;
              post_cnt     <= (ADDR_W+1)'(1);
              if (post_eff == (ADDR_W+1)'(1)) o_done <= 1'b1;
            end
          S_POST: begin
            post_cnt <= post_cnt_nxt;
            if (post_cnt_nxt == post_eff) o_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_state = state;

  adc_capture_wrport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wrport (
    .clk       (i_62clk),
    .rst       (i_reset),
    .clr       (arm_ok),
    .wr_req    (wr_req),
    .data      (i_adc_data),
    .wraddress (o_wraddress),
    .wrdata    (o_wrdata),
    .wren      (o_wren),
    .byteen    (o_byteen),
    .ptr       (wr_ptr)
  );

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: stimulus pushes expected BRAM writes,
// an independent monitor pops and compares them whenever o_wren is seen.
module tb_adc_capture_ctrl;
  import adc_capture_pkg::*;

  localparam int DW    = 64;
  localparam int AW    = 14;
  localparam int DEPTH = 16384;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   adc_data;
  logic            adc_valid, arm, abort, trig;
  logic [AW:0]     capture_len;
  logic [AW-1:0]   pretrig_len;
  logic [AW-1:0]   wraddress, start_addr, trig_addr;
  logic [DW-1:0]   wrdata;
  logic            wren, busy, done;
  logic [DW/8-1:0] byteen;
  logic [2:0]      state;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wren_count = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adc_capture_ctrl dut (
    .i_62clk       (clk),
    .i_reset       (reset),
    .i_adc_data    (adc_data),
    .i_adc_valid   (adc_valid),
    .i_arm         (arm),
    .i_abort       (abort),
    .i_trig        (trig),
    .i_capture_len (capture_len),
    .i_pretrig_len (pretrig_len),
    .o_wraddress   (wraddress),
    .o_wrdata      (wrdata),
    .o_wren        (wren),
    .o_byteen      (byteen),
    .o_busy        (busy),
    .o_done        (done),
    .o_start_addr  (start_addr),
    .o_trig_addr   (trig_addr),
    .o_state       (state)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic t,
                               input logic a, input logic ab);
    @(posedge clk);
    #1;
    adc_valid = v;
    adc_data  = d;
    trig      = t;
    arm       = a;
    abort     = ab;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0, 1'b0);
  endtask

  // Monitor: every written word must be the next expected one, one cycle late.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      checkOutput("byteen", 64'(byteen), wren ? 64'hff : 64'h0);
      if (wren) begin
        wren_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_wren: got write to 0x%0h, expected no write", wraddress);
        end else begin
          e = exp_q.pop_front();
          checkOutput("wraddress", 64'(wraddress), 64'(e.addr));
          checkOutput("wrdata", wrdata, e.data);
          checkOutput("done_with_write", 64'(done), 64'(e.last));
          checkOutput("wren_latency", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  // Reference: the trigger word is index k = pre_eff + trig_off among valid
  // words after arm (earlier triggers fall inside PRE and are ignored), and
  // the capture writes words 0 .. k+post_eff-1 at address index mod DEPTH.
  task automatic run_capture(input int cap_len, input int pre_len, input int trig_off,
                             input int gap, input bit trig_always);
    int len_eff, pre_eff, post_eff, k, total, w0, n;
    logic [DW-1:0] d;
    logic t;
    exp_t e;
    len_eff  = (cap_len == 0 || cap_len > DEPTH) ? DEPTH : cap_len;
    pre_eff  = (pre_len < len_eff) ? pre_len : len_eff - 1;
    post_eff = len_eff - pre_eff;
    k        = trig_always ? pre_eff : pre_eff + trig_off;
    total    = k + post_eff;
    w0       = wren_count;

    capture_len = (AW+1)'(cap_len);
    pretrig_len = AW'(pre_len);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle_cycle();
    checkOutput("state_after_arm", 64'(state), (pre_eff == 0) ? 64'd2 : 64'd1);
    checkOutput("busy_after_arm", 64'(busy), 64'd1);
    checkOutput("done_after_arm", 64'(done), 64'd0);

    for (int j = 0; j < total + 3; j++) begin
      n = (gap < 0) ? int'($urandom_range(2)) : gap;
      repeat (n) idle_cycle();
      d = {$urandom, $urandom};
      if (trig_always)      t = 1'b1;
      else if (j < pre_eff) t = 1'($urandom_range(1));
      else if (j < k)       t = 1'b0;
      else if (j == k)      t = 1'b1;
      else                  t = 1'($urandom_range(1));
      applyStimulus(1'b1, d, t, 1'b0, 1'b0);
      if (j < total) begin
        e.addr = AW'(j % DEPTH);
        e.data = d;
        e.last = (j == total - 1);
        e.due  = cyc + 1;
        exp_q.push_back(e);
      end
    end
    idle_cycle();
    idle_cycle();

    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("wren_pulses", 64'(wren_count - w0), 64'(total));
    checkOutput("done_held", 64'(done), 64'd1);
    checkOutput("state_done", 64'(state), 64'd4);
    checkOutput("busy_done", 64'(busy), 64'd0);
    checkOutput("trig_addr", 64'(trig_addr), 64'(k % DEPTH));
    checkOutput("start_addr", 64'(start_addr), 64'((k - pre_eff) % DEPTH));
    exp_q.delete();
  endtask

  task automatic run_abort_test();
    logic [DW-1:0] d;
    exp_t e;
    int w0;
    w0 = wren_count;
    capture_len = 15'd32;
    pretrig_len = 14'd4;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 6; j++) begin
      d = {$urandom, $urandom};
      applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
      e.addr = AW'(j);
      e.data = d;
      e.last = 1'b0;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1);
    idle_cycle();
    checkOutput("abort_state", 64'(state), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    checkOutput("abort_queue_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("abort_wren_pulses", 64'(wren_count - w0), 64'd6);
    exp_q.delete();
  endtask

  task automatic run_reset_test();
    logic [DW-1:0] d;
    exp_t e;
    capture_len = 15'd40;
    pretrig_len = 14'd2;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      d = {$urandom, $urandom};
      applyStimulus(1'b1, d, (j == 5), 1'b0, 1'b0);
      e.addr = AW'(j);
      e.data = d;
      e.last = 1'b0;
      e.due  = cyc + 1;
      exp_q.push_back(e);
    end
    idle_cycle();
    checkOutput("pre_reset_state", 64'(state), 64'd3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_wren", 64'(wren), 64'd0);
    checkOutput("rst_wraddress", 64'(wraddress), 64'd0);
    checkOutput("rst_wrdata", wrdata, 64'd0);
    checkOutput("rst_byteen", 64'(byteen), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_start", 64'(start_addr), 64'd0);
    checkOutput("rst_trig", 64'(trig_addr), 64'd0);
    checkOutput("rst_state", 64'(state), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    run_capture(12, 3, 2, -1, 1'b0);
  endtask

  initial begin
    int cl, pl;
    reset       = 1'b1;
    adc_data    = '0;
    adc_valid   = 1'b0;
    arm         = 1'b0;
    abort       = 1'b0;
    trig        = 1'b0;
    capture_len = '0;
    pretrig_len = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", 64'(state), 64'd0);
    checkOutput("reset_wren", 64'(wren), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    $display("[TB] directed len=16 pretrig=4 trigger at address 9");
    run_capture(16, 4, 5, 0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    checkOutput("abort_from_done_done", 64'(done), 64'd0);
    checkOutput("abort_from_done_state", 64'(state), 64'd0);

    $display("[TB] wrap len=16384 pretrig=100 trigger at write 20000");
    run_capture(0, 100, 19900, 0, 1'b0);

    $display("[TB] early trigger pretrig=8");
    run_capture(24, 8, 0, 0, 1'b1);

    $display("[TB] gapped valid len=4 pretrig=0");
    run_capture(4, 0, 0, 2, 1'b0);

    $display("[TB] abort in ARMED with simultaneous arm");
    run_abort_test();

    $display("[TB] oversize length with pretrig clamp, post of one word");
    run_capture(20000, 16383, 3, 0, 1'b0);

    $display("[TB] randomized captures");
    for (int r = 0; r < 8; r++) begin
      cl = int'($urandom_range(40, 1));
      pl = int'($urandom_range(45));
      run_capture(cl, pl, int'($urandom_range(20)), -1, 1'b0);
    end

    $display("[TB] asynchronous reset mid-POST");
    run_reset_test();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
